// File: rtl/mul_arb.sv
// Round-robin issue arbiter for a shared pipelined 24x24 multiplier, with tag pipeline.
// Optional MUL_ARB_HOLD_EN adds a hold input that blocks new issue while results drain.
module mul_arb #(
  parameter int NREQ    = 4,
  parameter int IDW     = 2,
  parameter int MUL_LAT = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req,
`ifdef MUL_ARB_HOLD_EN
  input  logic                 hold,
`endif
  input  logic [NREQ*24-1:0]   opa_i,
  input  logic [NREQ*24-1:0]   opb_i,
  output logic [NREQ-1:0]      gnt,
  output logic [23:0]          mul_opa,
  output logic [23:0]          mul_opb,
  input  logic [47:0]          mul_prod,
  output logic                 res_vld,
  output logic [IDW-1:0]       res_id,
  output logic [47:0]          res_prod,
  output logic                 busy
);

  logic [IDW-1:0]     ptr_q;
  logic [IDW-1:0]     ptr_d;
  logic               any_gnt;
  logic [IDW-1:0]     win_id;
  logic [IDW:0]       idx;
  logic               blk;
  logic [MUL_LAT-1:0] vld_q;
  logic [IDW-1:0]     id_q [MUL_LAT];

`ifdef MUL_ARB_HOLD_EN
  assign blk = rst | hold;
`else
  assign blk = rst;
`endif

  // Scan ptr, ptr+1, ... wrapping at NREQ; first asserted request wins.
  always_comb begin
    any_gnt = 1'b0;
    win_id  = '0;
    idx     = '0;
    for (int i = 0; i < NREQ; i++) begin
      idx = {1'b0, ptr_q} + (IDW+1)'(i);
      if (idx >= (IDW+1)'(NREQ))
        idx = idx - (IDW+1)'(NREQ);
      for (int k = 0; k < NREQ; k++) begin
        if (!any_gnt && !blk && req[k] &&
            idx == (IDW+1)'(k)) begin
          any_gnt = 1'b1;
          win_id  = IDW'(k);
        end
      end
    end
  end

  always_comb begin
    gnt     = '0;
    mul_opa = '0;
    mul_opb = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (any_gnt && win_id == IDW'(k)) begin
        gnt[k]  = 1'b1;
        mul_opa = opa_i[k*24 +: 24];
        mul_opb = opb_i[k*24 +: 24];
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (any_gnt) begin
      if (win_id == IDW'(NREQ-1))
        ptr_d = '0;
      else
        ptr_d = win_id + IDW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q <= '0;
      vld_q <= '0;
      for (int i = 0; i < MUL_LAT; i++)
        id_q[i] <= '0;
    end else begin
      ptr_q    <= ptr_d;
      vld_q[0] <= any_gnt;
      id_q[0]  <= win_id;
      for (int i = 1; i < MUL_LAT; i++) begin
        vld_q[i] <= vld_q[i-1];
        id_q[i]  <= id_q[i-1];
      end
    end
  end

  assign res_vld  = vld_q[MUL_LAT-1];
  assign res_id   = id_q[MUL_LAT-1];
  assign res_prod = mul_prod;
  assign busy     = |vld_q;

endmodule

// File: tb/tb_mul_arb.sv
// Bench for mul_arb: directed issue vectors, scoreboard-checked tagged results.
// Includes a 2-stage behavioural multiplier standing in for the shared unit.
module tb_mul_arb;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req;
`ifdef MUL_ARB_HOLD_EN
  logic        hold;
`endif
  logic [95:0] opa_i;
  logic [95:0] opb_i;
  logic [3:0]  gnt;
  logic [23:0] mul_opa;
  logic [23:0] mul_opb;
  logic [47:0] mul_prod;
  logic        res_vld;
  logic [1:0]  res_id;
  logic [47:0] res_prod;
  logic        busy;

  int n_tests = 0;
  int n_fail  = 0;

  logic [49:0] sb_q[$];

  always #5 clk = ~clk;

  mul_arb #(.NREQ(4), .IDW(2), .MUL_LAT(2)) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
`ifdef MUL_ARB_HOLD_EN
    .hold     (hold),
`endif
    .opa_i    (opa_i),
    .opb_i    (opb_i),
    .gnt      (gnt),
    .mul_opa  (mul_opa),
    .mul_opb  (mul_opb),
    .mul_prod (mul_prod),
    .res_vld  (res_vld),
    .res_id   (res_id),
    .res_prod (res_prod),
    .busy     (busy)
  );

  logic [47:0] p1;
  logic [47:0] p2;
  always @(posedge clk) begin
    p1 <= {24'b0, mul_opa} * {24'b0, mul_opb};
    p2 <= p1;
  end
  assign mul_prod = p2;

  task automatic chk(input string name,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst === 1'b0 && res_vld === 1'b1) begin
      if (sb_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_res act_id=%0d exp=none",
                 res_id);
      end else begin
        logic [49:0] e;
        e = sb_q.pop_front();
        chk("res_id", 64'(res_id), 64'(e[49:48]));
        chk("res_prod", 64'(res_prod), 64'(e[47:0]));
      end
    end
  end

  task automatic cyc(input logic [3:0]  r,
                     input logic [95:0] a,
                     input logic [95:0] b,
                     input logic [3:0]  eg,
                     input logic        push,
                     input logic [1:0]  eid,
                     input logic [47:0] ep);
    req   = r;
    opa_i = a;
    opb_i = b;
    @(negedge clk);
    chk("gnt", 64'(gnt), 64'(eg));
    if (push)
      sb_q.push_back({eid, ep});
    @(posedge clk);
    #1;
  endtask

  logic [95:0] A, B, Z;
  logic [95:0] a1, b1;

  initial begin
    Z = '0;
    for (int k = 0; k < 4; k++) begin
      A[k*24 +: 24] = 24'(k + 1);
      B[k*24 +: 24] = 24'(k + 2);
    end
    rst   = 1'b1;
    req   = 4'b1111;
    opa_i = A;
    opb_i = B;
`ifdef MUL_ARB_HOLD_EN
    hold  = 1'b0;
`endif
    @(negedge clk);
    chk("rst_gnt", 64'(gnt), 64'h0);
    chk("rst_vld", 64'(res_vld), 64'h0);
    chk("rst_id", 64'(res_id), 64'h0);
    chk("rst_busy", 64'(busy), 64'h0);
    chk("rst_opa", 64'(mul_opa), 64'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    req = 4'b0000;

    // rotation from ptr=0
    for (int i = 0; i < 8; i++) begin
      int k;
      k = i % 4;
      cyc(4'b1111, A, B, 4'(1 << k), 1'b1, 2'(k),
          48'((k + 1) * (k + 2)));
    end
    chk("busy_tail", 64'(busy), 64'h1);
    cyc(4'b0000, Z, Z, 4'b0000, 1'b0, 2'd0, 48'd0);
    cyc(4'b0000, Z, Z, 4'b0000, 1'b0, 2'd0, 48'd0);
    chk("busy_drop", 64'(busy), 64'h0);

    // single request, lane 2: 3*5
    a1 = '0; b1 = '0;
    a1[48 +: 24] = 24'h000003;
    b1[48 +: 24] = 24'h000005;
    cyc(4'b0100, a1, b1, 4'b0100, 1'b1, 2'd2, 48'h00000000000F);
    cyc(4'b0000, Z, Z, 4'b0000, 1'b0, 2'd0, 48'd0);
    chk("busy_mid", 64'(busy), 64'h1);
    cyc(4'b0000, Z, Z, 4'b0000, 1'b0, 2'd0, 48'd0);

    // ptr=3 -> grant 0 moves ptr to 1; then 1001 wraps to 3 then 0
    a1 = '0; b1 = '0;
    a1[0 +: 24]  = 24'd7;
    b1[0 +: 24]  = 24'd9;
    a1[72 +: 24] = 24'h10;
    b1[72 +: 24] = 24'h10;
    cyc(4'b0001, a1, b1, 4'b0001, 1'b1, 2'd0, 48'h3F);
    cyc(4'b1001, a1, b1, 4'b1000, 1'b1, 2'd3, 48'h100);
    cyc(4'b1001, a1, b1, 4'b0001, 1'b1, 2'd0, 48'h3F);

    // boundary operands on lane 1 (ptr=1)
    a1 = '0; b1 = '0;
    a1[24 +: 24] = 24'hFFFFFF;
    b1[24 +: 24] = 24'hFFFFFF;
    cyc(4'b0010, a1, b1, 4'b0010, 1'b1, 2'd1, 48'hFFFFFE000001);
    repeat (3)
      cyc(4'b0000, Z, Z, 4'b0000, 1'b0, 2'd0, 48'd0);

    // reset mid-flight: grant at T (ptr=2 -> lane 0), rst in T+1
    cyc(4'b0001, A, B, 4'b0001, 1'b0, 2'd0, 48'd0);
    rst = 1'b1;
    req = 4'b0100;
    @(negedge clk);
    chk("mid_rst_gnt", 64'(gnt), 64'h0);
    chk("mid_rst_vld", 64'(res_vld), 64'h0);
    chk("mid_rst_busy", 64'(busy), 64'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    req = 4'b0000;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("post_rst_vld", 64'(res_vld), 64'h0);
      chk("post_rst_busy", 64'(busy), 64'h0);
      @(posedge clk);
      #1;
    end
    cyc(4'b1010, A, B, 4'b0010, 1'b1, 2'd1, 48'd6);

`ifdef MUL_ARB_HOLD_EN
    // ptr=2: issue lane 2, then hold 3 cycles, then frozen ptr=3 wins
    cyc(4'b0100, A, B, 4'b0100, 1'b1, 2'd2, 48'd12);
    hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc(4'b1111, A, B, 4'b0000, 1'b0, 2'd0, 48'd0);
    end
    hold = 1'b0;
    cyc(4'b1111, A, B, 4'b1000, 1'b1, 2'd3, 48'd20);
`endif

    repeat (4)
      cyc(4'b0000, Z, Z, 4'b0000, 1'b0, 2'd0, 48'd0);
    chk("sb_empty", 64'(sb_q.size()), 64'h0);
    chk("end_busy", 64'(busy), 64'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
